// File: rtl/econet_handshake_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : econet_handshake_ctrl
// Brief   : Econet four-way handshake receiver (scout/ACK/data/ACK) controller
// Revision: 1.0
// ============================================================================
module econet_handshake_ctrl #(
    parameter logic [15:0] TIMEOUT_US = 16'd2000
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        tick_us,
    input  logic        frame_valid,
    input  logic [8:0]  frame_len,
    input  logic [15:0] frame_dst,
    input  logic [15:0] frame_src,
    input  logic [7:0]  scout_ctrl,
    input  logic [7:0]  scout_port,
    input  logic [7:0]  listen_port,
    input  logic        tx_done,
    input  logic        cpu_ack,
    output logic        frame_consume,
    output logic        tx_req,
    output logic [15:0] tx_dst,
    output logic        data_ready,
    output logic [15:0] rx_src,
    output logic [7:0]  rx_ctrl,
    output logic [7:0]  rx_port,
    output logic        timeout_err,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACK_SCOUT = 3'd1,
        WAIT_DATA = 3'd2,
        DATA_ACK  = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  sync_q;
    logic [15:0] timer_q, timer_d;
    logic        consume_q, tx_req_q, data_ready_q, timeout_q, timeout_d;
    logic        latch_d;
    logic [15:0] rx_src_q;
    logic [7:0]  rx_ctrl_q, rx_port_q;

    // sync_q[1] is the synchronized level, sync_q[2] its previous value
    logic w_frame_evt;
    logic w_scout_ok;
    logic w_data_ok;

    assign w_frame_evt = sync_q[1] & ~sync_q[2];
    assign w_scout_ok  = enable && (frame_len == 9'd6) && (frame_dst != 16'hFFFF) &&
                         ((listen_port == 8'h00) || (scout_port == listen_port));
    assign w_data_ok   = (frame_src == rx_src_q) && (frame_len >= 9'd4);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        timeout_d = 1'b0;
        latch_d   = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_frame_evt && w_scout_ok) begin
                        state_d = ACK_SCOUT;
                        latch_d = 1'b1;
                    end
                end
                ACK_SCOUT: begin
                    if (tx_done) begin
                        state_d = WAIT_DATA;
                        timer_d = 16'd0;
                    end
                end
                WAIT_DATA: begin
                    // A matching frame takes priority over an expiring timer
                    if (w_frame_evt && w_data_ok) begin
                        state_d = DATA_ACK;
                    end else if (timer_q >= TIMEOUT_US) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end else if (tick_us && (timer_q != 16'hFFFF)) begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                DATA_ACK: begin
                    if (tx_done) state_d = DONE;
                end
                DONE: begin
                    if (cpu_ack) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sync_q       <= 3'b000;
            timer_q      <= 16'd0;
            consume_q    <= 1'b0;
            tx_req_q     <= 1'b0;
            data_ready_q <= 1'b0;
            timeout_q    <= 1'b0;
            rx_src_q     <= 16'd0;
            rx_ctrl_q    <= 8'd0;
            rx_port_q    <= 8'd0;
        end else begin
            sync_q       <= {sync_q[1:0], frame_valid};
            consume_q    <= w_frame_evt;
            state_q      <= state_d;
            timer_q      <= timer_d;
            timeout_q    <= timeout_d;
            tx_req_q     <= (state_d == ACK_SCOUT) || (state_d == DATA_ACK);
            data_ready_q <= (state_d == DONE);
            if (latch_d) begin
                rx_src_q  <= frame_src;
                rx_ctrl_q <= scout_ctrl;
                rx_port_q <= scout_port;
            end
        end
    end

    assign frame_consume = consume_q;
    assign tx_req        = tx_req_q;
    assign tx_dst        = rx_src_q;
    assign data_ready    = data_ready_q;
    assign timeout_err   = timeout_q;
    assign rx_src        = rx_src_q;
    assign rx_ctrl       = rx_ctrl_q;
    assign rx_port       = rx_port_q;
    assign state         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_econet_handshake_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_econet_handshake_ctrl
// Brief   : Directed self-checking bench for econet_handshake_ctrl
// Revision: 1.0
// ============================================================================
module tb_econet_handshake_ctrl;

    logic        sys_clk = 1'b0;
    logic        reset, enable, tick_us, frame_valid, tx_done, cpu_ack;
    logic [8:0]  frame_len;
    logic [15:0] frame_dst, frame_src;
    logic [7:0]  scout_ctrl, scout_port, listen_port;
    logic        frame_consume, tx_req, data_ready, timeout_err;
    logic [15:0] tx_dst, rx_src;
    logic [7:0]  rx_ctrl, rx_port;
    logic [2:0]  state;

    int n_checks = 0;
    int n_pass   = 0;

    econet_handshake_ctrl #(.TIMEOUT_US(16'd10)) u_dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .enable       (enable),
        .tick_us      (tick_us),
        .frame_valid  (frame_valid),
        .frame_len    (frame_len),
        .frame_dst    (frame_dst),
        .frame_src    (frame_src),
        .scout_ctrl   (scout_ctrl),
        .scout_port   (scout_port),
        .listen_port  (listen_port),
        .tx_done      (tx_done),
        .cpu_ack      (cpu_ack),
        .frame_consume(frame_consume),
        .tx_req       (tx_req),
        .tx_dst       (tx_dst),
        .data_ready   (data_ready),
        .rx_src       (rx_src),
        .rx_ctrl      (rx_ctrl),
        .rx_port      (rx_port),
        .timeout_err  (timeout_err),
        .state        (state)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Event is seen on the third edge after frame_valid rises; consume follows it
    task automatic send_frame(input logic [8:0] len, input logic [15:0] dst,
                              input logic [15:0] src, input logic [7:0] port,
                              input logic [2:0] exp_state);
        frame_len   = len;
        frame_dst   = dst;
        frame_src   = src;
        scout_ctrl  = 8'h80;
        scout_port  = port;
        frame_valid = 1'b1;
        step(); step(); step();
        check("consume_pulse", frame_consume, 1'b1);
        check("state_after_frame", state, exp_state);
        step();
        check("consume_once", frame_consume, 1'b0);
        frame_valid = 1'b0;
        step(); step(); step();
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic pulse_tick();
        tick_us = 1'b1;
        step();
        tick_us = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; tick_us = 1'b0; frame_valid = 1'b0;
        tx_done = 1'b0; cpu_ack = 1'b0; frame_len = '0; frame_dst = '0;
        frame_src = '0; scout_ctrl = '0; scout_port = '0; listen_port = 8'h99;
        step(); step();
        check("rst_state", state, 3'd0);
        check("rst_tx_req", tx_req, 1'b0);
        check("rst_consume", frame_consume, 1'b0);
        check("rst_data_ready", data_ready, 1'b0);
        check("rst_timeout", timeout_err, 1'b0);
        check("rst_rx_src", rx_src, 16'h0000);
        check("rst_tx_dst", tx_dst, 16'h0000);
        reset = 1'b0; enable = 1'b1;
        step();

        // Full handshake
        send_frame(9'd6, 16'h0001, 16'h0102, 8'h99, 3'd1);
        check("hs_tx_req_scout", tx_req, 1'b1);
        check("hs_tx_dst_scout", tx_dst, 16'h0102);
        check("hs_rx_ctrl", rx_ctrl, 8'h80);
        check("hs_rx_port", rx_port, 8'h99);
        pulse_tx_done();
        check("hs_wait_state", state, 3'd2);
        check("hs_wait_tx_req", tx_req, 1'b0);
        send_frame(9'd20, 16'h0001, 16'h0102, 8'h00, 3'd3);
        check("hs_tx_req_data", tx_req, 1'b1);
        check("hs_tx_dst_data", tx_dst, 16'h0102);
        pulse_tx_done();
        check("hs_done_state", state, 3'd4);
        check("hs_data_ready", data_ready, 1'b1);
        check("hs_done_tx_req", tx_req, 1'b0);
        step(); step();
        check("hs_data_ready_held", data_ready, 1'b1);
        cpu_ack = 1'b1; step(); cpu_ack = 1'b0;
        check("hs_idle_state", state, 3'd0);
        check("hs_data_ready_low", data_ready, 1'b0);

        // Filtering
        send_frame(9'd6, 16'hFFFF, 16'h0102, 8'h99, 3'd0);
        check("flt_bcast_tx_req", tx_req, 1'b0);
        send_frame(9'd6, 16'h0001, 16'h0102, 8'h55, 3'd0);
        check("flt_port_tx_req", tx_req, 1'b0);
        send_frame(9'd7, 16'h0001, 16'h0102, 8'h99, 3'd0);
        check("flt_len_tx_req", tx_req, 1'b0);

        // Wildcard listen port, then timeout
        listen_port = 8'h00;
        send_frame(9'd6, 16'h0001, 16'h0102, 8'h55, 3'd1);
        check("any_port_rx_port", rx_port, 8'h55);
        pulse_tx_done();
        check("to_wait", state, 3'd2);
        for (int i = 0; i < 9; i++) pulse_tick();
        check("to_not_yet", timeout_err, 1'b0);
        tick_us = 1'b1; step(); tick_us = 1'b0;
        check("to_limit_state", state, 3'd2);
        step();
        check("to_pulse", timeout_err, 1'b1);
        check("to_idle", state, 3'd0);
        step();
        check("to_single", timeout_err, 1'b0);

        // Foreign source and short data frame, then reset during DATA_ACK
        listen_port = 8'h99;
        send_frame(9'd6, 16'h0001, 16'h0102, 8'h99, 3'd1);
        pulse_tx_done();
        send_frame(9'd20, 16'h0001, 16'h0304, 8'h00, 3'd2);
        send_frame(9'd3, 16'h0001, 16'h0102, 8'h00, 3'd2);
        send_frame(9'd4, 16'h0001, 16'h0102, 8'h00, 3'd3);
        reset = 1'b1;
        #1;
        check("arst_state", state, 3'd0);
        check("arst_tx_req", tx_req, 1'b0);
        check("arst_rx_src", rx_src, 16'h0000);
        step();
        reset = 1'b0;
        pulse_tx_done();
        check("arst_late_tx_done", state, 3'd0);
        check("arst_no_tx_req", tx_req, 1'b0);

        // Enable dropped in ACK_SCOUT
        send_frame(9'd6, 16'h0001, 16'h0102, 8'h99, 3'd1);
        enable = 1'b0;
        step();
        check("en_state", state, 3'd0);
        check("en_tx_req", tx_req, 1'b0);
        check("en_rx_kept", rx_src, 16'h0102);
        enable = 1'b1;
        pulse_tx_done();
        check("en_late_tx_done", state, 3'd0);
        cpu_ack = 1'b1; step(); cpu_ack = 1'b0;
        check("en_stray_cpu_ack", state, 3'd0);

        // Matching frame in the same cycle the timer reaches the limit
        send_frame(9'd6, 16'h0001, 16'h0102, 8'h99, 3'd1);
        pulse_tx_done();
        for (int i = 0; i < 8; i++) pulse_tick();
        frame_len = 9'd20; frame_src = 16'h0102; frame_valid = 1'b1; tick_us = 1'b1;
        step(); step();
        tick_us = 1'b0;
        step();
        check("co_state", state, 3'd3);
        check("co_no_timeout", timeout_err, 1'b0);
        check("co_consume", frame_consume, 1'b1);
        step();
        check("co_no_timeout_later", timeout_err, 1'b0);
        check("co_state_held", state, 3'd3);
        frame_valid = 1'b0;
        pulse_tx_done();
        check("co_done", state, 3'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/econet_handshake_ctrl.md
ECONET_HANDSHAKE_CTRL -- requirements
Module: econet_handshake_ctrl

Interface
REQ-001 Parameter TIMEOUT_US, default 2000, SHALL set the data-frame wait limit in tick_us strobes (16-bit).
REQ-002 sys_clk  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-004 enable  in  1  high = controller active.
REQ-005 tick_us  in  1  one-cycle strobe every microsecond.
REQ-006 frame_valid  in  1  level from the receiver, asynchronous to sys_clk, high while a valid frame is held.
REQ-007 frame_len  in  9  byte count of the held frame, including the address bytes.
REQ-008 frame_dst / frame_src  in  16 each  destination and source station/net of the held frame.
REQ-009 scout_ctrl / scout_port  in  8 each  frame bytes 4 and 5.
REQ-010 listen_port  in  8  accepted port; 0 = any port.
REQ-011 tx_done  in  1  one-cycle pulse from the transmitter when the requested ACK frame has completed.
REQ-012 cpu_ack  in  1  one-cycle pulse from the CPU releasing a completed transaction.
REQ-013 frame_consume  out  1  one-cycle pulse that clears the receiver valid flag.
REQ-014 tx_req / tx_dst  out  1 / 16  ACK transmit request and its destination.
REQ-015 data_ready  out  1  transaction complete, awaiting CPU.
REQ-016 rx_src / rx_ctrl / rx_port  out  16 / 8 / 8  latched scout fields.
REQ-017 timeout_err  out  1  one-cycle pulse when the data-frame wait expires.
REQ-018 state  out  3  current state encoding.

Function
REQ-019 frame_valid SHALL pass through a 2-flop synchronizer; a frame event SHALL be the rising edge of the synchronized level.
REQ-020 The frame_* inputs SHALL be sampled in the event cycle; they are stable while frame_valid is held.
REQ-021 Every frame event, in any state, SHALL produce frame_consume exactly one cycle later, whether the frame is accepted or discarded.
REQ-022 States and encodings SHALL be IDLE=0, ACK_SCOUT=1, WAIT_DATA=2, DATA_ACK=3, DONE=4.
REQ-023 In IDLE, an event is accepted as a scout only if all of: enable=1, frame_len==6, frame_dst!=16'hFFFF, and (scout_port==listen_port or listen_port==0).
REQ-024 On an accepted scout the block SHALL latch rx_src, rx_ctrl and rx_port and go to ACK_SCOUT; any other event in IDLE SHALL be discarded with no state change.
REQ-025 In ACK_SCOUT, tx_req=1 and tx_dst=rx_src; tx_done SHALL move to WAIT_DATA and clear the timer.
REQ-026 In WAIT_DATA, the timer SHALL increment on each tick_us.
REQ-027 In WAIT_DATA, an event with frame_src==rx_src and frame_len>=4 SHALL move to DATA_ACK; events from any other source SHALL be discarded and the timer continues.
REQ-028 In WAIT_DATA, when the timer reaches TIMEOUT_US the block SHALL pulse timeout_err for one cycle and go to IDLE.
REQ-029 If a matching event and the timeout coincide in the same cycle, the event SHALL win and timeout_err SHALL not pulse.
REQ-030 In DATA_ACK, tx_req=1 and tx_dst=rx_src; tx_done SHALL move to DONE.
REQ-031 In DONE, data_ready=1; cpu_ack SHALL return to IDLE with data_ready low in the next cycle; events in DONE SHALL be discarded.
REQ-032 tx_req SHALL be high only in ACK_SCOUT and DATA_ACK; tx_done outside those states SHALL be ignored.
REQ-033 cpu_ack outside DONE SHALL be ignored.
REQ-034 enable=0 SHALL force IDLE on the next clock from any state, dropping tx_req and data_ready; rx_* SHALL keep their last values.
REQ-035 The timer SHALL saturate and never wrap.

Reset
REQ-036 While reset=1: state=IDLE, the timer and synchronizer are 0, and tx_req, frame_consume, data_ready and timeout_err are 0.
REQ-037 While reset=1: tx_dst, rx_src, rx_ctrl and rx_port are 0.
REQ-038 After a reset asserted mid-transaction, no tx_req SHALL be issued until a new scout is accepted.

Verification
REQ-039 Full handshake: listen_port=0x99; scout len=6, src=0x0102, port=0x99; tx_done; data frame len=20, src=0x0102; tx_done; cpu_ack -> tx_dst=0x0102 on both ACKs, data_ready=1 until cpu_ack, two frame_consume pulses, state sequence 0,1,2,3,4,0.
REQ-040 Filtering: broadcast scout (dst=0xFFFF), port 0x55 with listen_port=0x99, and len=7 -> each gives frame_consume, state stays 0, tx_req never asserted.
REQ-041 Timeout: TIMEOUT_US=10, scout ACKed, no data frame, 10 tick_us -> timeout_err pulses once, state=0.
REQ-042 Foreign source: in WAIT_DATA, data frame from src=0x0304 -> consumed and discarded, still in WAIT_DATA; a later frame from 0x0102 -> DATA_ACK.
REQ-043 Coincidence: matching data frame event in the same cycle the timer reaches the limit -> DATA_ACK, no timeout_err.
REQ-044 Abort: enable dropped in ACK_SCOUT, and separately reset asserted in DATA_ACK -> tx_req=0 next cycle, state=0; a late tx_done causes no transition.
